fsm_seq_ctrl: RTL and testbench

//  Sequencer/host for one fsm_design nibble-serial datapath (N=64, N_width=4).

---
 rtl/fsm_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_fsm_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_ctrl.sv
// Command sequencer for one nibble-serial fsm_design datapath: loads operands, replays an
// op program, steers the datapath to OUTPUT and reassembles the result. FSM_SEQ_WDOG_EN adds a watchdog.
module fsm_seq_ctrl #(
  parameter int unsigned N          = 64,
  parameter int unsigned N_WIDTH    = 4,
  parameter int unsigned PROG_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [N-1:0]                    cmd_a_i,
  input  logic [N-1:0]                    cmd_b_i,
  input  logic [2*PROG_DEPTH-1:0]         cmd_prog_i,
  input  logic [$clog2(PROG_DEPTH+1)-1:0] cmd_len_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [N-1:0]                    rsp_data_o,
  output logic                            rsp_err_o,
  output logic                            dp_start_o,
  output logic                            dp_en_o,
  output logic [N_WIDTH-1:0]              dp_a_o,
  output logic [N_WIDTH-1:0]              dp_b_o,
  output logic [1:0]                      dp_op_o,
  input  logic [3:0]                      dp_state_i,
  input  logic                            dp_valid_i,
  input  logic [N_WIDTH-1:0]              dp_out_i
);

  localparam int unsigned NNIB = N / N_WIDTH;
  localparam int unsigned LenW = $clog2(PROG_DEPTH + 1);
  localparam int unsigned CntW = $clog2(NNIB + PROG_DEPTH + 1);
  localparam logic [LenW-1:0] LenMax = LenW'(PROG_DEPTH);
  localparam logic [CntW-1:0] NibLast = CntW'(NNIB - 1);

  localparam logic [3:0] DpS0   = 4'd0;
  localparam logic [3:0] DpS1   = 4'd1;
  localparam logic [3:0] DpS4   = 4'd4;
  localparam logic [3:0] DpIdle = 4'd8;

  typedef enum logic [2:0] {CIdle, CStart, CLoad, CRun, CDrain, CCollect, CDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [N-1:0]            a_q, a_d, b_q, b_d;
  logic [2*PROG_DEPTH-1:0] prog_q, prog_d;
  logic [LenW-1:0]         len_q, len_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [N-1:0]            rsp_data_q, rsp_data_d;

`ifdef FSM_SEQ_WDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT);
  // DONE becomes visible on the TIMEOUT-th cycle after the accepting edge.
  localparam logic [WdW-1:0] WdogLast = WdW'(TIMEOUT - 2);
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           rsp_err_q, rsp_err_d;
`endif

  assign cmd_ready_o = (state_q == CIdle) && (dp_state_i == DpIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    prog_d      = prog_q;
    len_d       = len_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      CIdle: begin
        if (cmd_valid_i && cmd_ready_o) begin
          a_d     = cmd_a_i;
          b_d     = cmd_b_i;
          prog_d  = cmd_prog_i;
          len_d   = (cmd_len_i > LenMax) ? LenMax : cmd_len_i;
          cnt_d   = '0;
          state_d = CStart;
        end
      end
      CStart: state_d = CLoad;
      CLoad: begin
        a_d   = a_q >> N_WIDTH;
        b_d   = b_q >> N_WIDTH;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == NibLast) begin
          cnt_d   = '0;
          state_d = (len_q != '0) ? CRun : CDrain;
        end
      end
      CRun: begin
        prog_d = prog_q >> 2;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(len_q) - 1'b1) begin
          cnt_d   = '0;
          state_d = CDrain;
        end
      end
      CDrain, CCollect: begin
        // Result nibbles arrive LSB first; shifting in from the top leaves nibble 0 at the bottom.
        if (dp_valid_i) begin
          rsp_data_d = {dp_out_i, rsp_data_q[N-1:N_WIDTH]};
          cnt_d      = cnt_q + 1'b1;
          state_d    = CCollect;
          if (cnt_q == NibLast) begin
            cnt_d       = '0;
            state_d     = CDone;
            rsp_valid_d = 1'b1;
          end
        end
      end
      CDone: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = CIdle;
        end
      end
      default: state_d = CIdle;
    endcase
`ifdef FSM_SEQ_WDOG_EN
    rsp_err_d = rsp_err_q;
    wdog_d    = '0;
    if (state_q == CDone) begin
      wdog_d = wdog_q;
      if (rsp_ready_i) rsp_err_d = 1'b0;
    end else if (state_q != CIdle) begin
      wdog_d = wdog_q + 1'b1;
      if (wdog_q == WdogLast) begin
        state_d     = CDone;
        cnt_d       = '0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_data_d  = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prog_q      <= '0;
      len_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prog_q      <= prog_d;
      len_q       <= len_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef FSM_SEQ_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err_o = rsp_err_q;
`else
  // Without the watchdog the timeout limit has no consumer.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign rsp_err_o      = 1'b0;
`endif

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign dp_start_o  = (state_q == CStart);
  assign dp_en_o     = (state_q == CLoad);
  assign dp_a_o      = (state_q == CLoad) ? a_q[N_WIDTH-1:0] : '0;
  assign dp_b_o      = (state_q == CLoad) ? b_q[N_WIDTH-1:0] : '0;

  // While draining, steer the datapath toward S4 and then OUTPUT from wherever it sits.
  always_comb begin
    dp_op_o = 2'd0;
    if (state_q == CRun) begin
      dp_op_o = prog_q[1:0];
    end else if (state_q == CDrain) begin
      case (dp_state_i)
        DpS4:       dp_op_o = 2'd1;
        DpS0, DpS1: dp_op_o = 2'd2;
        default:    dp_op_o = 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: a small fsm_design stand-in, a transaction-level expectation model
// with a per-cycle compare, and directed commands with literal latencies and results.
`timescale 1ns/1ps
module tb_fsm_seq_ctrl;
  localparam int NNIB = 16;
  localparam int PD   = 8;
  localparam int TO   = 64;
  localparam logic [3:0] DP_IDLE   = 4'd8;
  localparam logic [3:0] DP_INPUT  = 4'd9;
  localparam logic [3:0] DP_OUTPUT = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_a = '0;
  logic [63:0] cmd_b = '0;
  logic [15:0] cmd_prog = '0;
  logic [3:0]  cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        dp_start, dp_en;
  logic [3:0]  dp_a, dp_b;
  logic [1:0]  dp_op;
  logic [3:0]  dps;
  logic        dp_valid;
  logic [3:0]  dp_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fsm_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_prog_i  (cmd_prog),
    .cmd_len_i   (cmd_len),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .dp_start_o  (dp_start),
    .dp_en_o     (dp_en),
    .dp_a_o      (dp_a),
    .dp_b_o      (dp_b),
    .dp_op_o     (dp_op),
    .dp_state_i  (dps),
    .dp_valid_i  (dp_valid),
    .dp_out_i    (dp_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Datapath stand-in: result value is preset per command, route table is fixed.
  logic [63:0] dp_res = '0;
  bit          stuck = 1'b0;
  int          icnt, ocnt;
  assign dp_valid = (dps == DP_OUTPUT);
  assign dp_out   = dp_valid ? dp_res[ocnt*4 +: 4] : 4'h0;

  function automatic logic [3:0] dp_next(input logic [3:0] s, input logic [1:0] op);
    case (s)
      4'd0:    return (op == 2'd1) ? 4'd0 : (op == 2'd2) ? 4'd4 : (op == 2'd3) ? 4'd1 : 4'd2;
      4'd1:    return (op == 2'd2) ? 4'd5 : (op == 2'd0) ? 4'd3 : 4'd1;
      4'd2:    return 4'd5;
      4'd3:    return 4'd6;
      4'd4:    return (op == 2'd1) ? DP_OUTPUT : 4'd4;
      4'd5:    return 4'd4;
      4'd6:    return 4'd7;
      4'd7:    return 4'd5;
      default: return s;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dps  <= DP_IDLE;
      icnt <= 0;
      ocnt <= 0;
    end else if (!stuck) begin
      if (dps == DP_IDLE) begin
        if (dp_start) begin
          dps  <= DP_INPUT;
          icnt <= 0;
        end
      end else if (dps == DP_INPUT) begin
        if (dp_en) begin
          icnt <= icnt + 1;
          if (icnt == NNIB - 1) dps <= 4'd0;
        end
      end else if (dps == DP_OUTPUT) begin
        ocnt <= ocnt + 1;
        if (ocnt == NNIB - 1) begin
          dps  <= DP_IDLE;
          ocnt <= 0;
        end
      end else begin
        dps <= dp_next(dps, dp_op);
      end
    end
  end

  // Expectation model: m_off is the cycle label relative to the accepting edge (START = 1).
  logic        m_busy, m_done, m_err;
  int          m_off, m_vcnt, m_len;
  logic [63:0] m_a, m_b, m_data;
  logic [15:0] m_prog;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_off <= 0; m_vcnt <= 0; m_len <= 0;
      m_a <= '0; m_b <= '0; m_data <= '0; m_prog <= '0;
    end else if (!m_busy) begin
      if (cmd_valid && dps == DP_IDLE) begin
        m_busy <= 1'b1; m_done <= 1'b0; m_err <= 1'b0;
        m_off <= 1; m_vcnt <= 0;
        m_a <= cmd_a; m_b <= cmd_b; m_prog <= cmd_prog;
        m_len <= (int'(cmd_len) > PD) ? PD : int'(cmd_len);
      end
    end else if (m_done) begin
      if (rsp_ready) begin
        m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      end
    end else begin
      m_off <= m_off + 1;
      if (m_off >= 18 + m_len && dp_valid) begin
        m_vcnt <= m_vcnt + 1;
        if (m_vcnt == NNIB - 1) begin
          m_done <= 1'b1;
          m_data <= dp_res;
        end
      end
`ifdef FSM_SEQ_WDOG_EN
      if (m_off + 1 == TO) begin
        m_done <= 1'b1; m_err <= 1'b1; m_data <= '0;
      end
`endif
    end
  end

  function automatic logic [1:0] drain_op(input logic [3:0] s);
    case (s)
      4'd4:       return 2'd1;
      4'd0, 4'd1: return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      logic       xs, xe, xr;
      logic [3:0] xa, xb;
      logic [1:0] xo;
      xs = 1'b0; xe = 1'b0; xa = 4'h0; xb = 4'h0; xo = 2'd0;
      if (m_busy && !m_done) begin
        if (m_off == 1) begin
          xs = 1'b1;
        end else if (m_off >= 2 && m_off <= 17) begin
          xe = 1'b1;
          xa = m_a[(m_off-2)*4 +: 4];
          xb = m_b[(m_off-2)*4 +: 4];
        end else if (m_off < 18 + m_len) begin
          xo = m_prog[(m_off-18)*2 +: 2];
        end else if (m_vcnt == 0) begin
          xo = drain_op(dps);
        end
      end
      xr = !m_busy && (dps == DP_IDLE);
      chk("cyc cmd_ready", 64'(cmd_ready), 64'(xr));
      chk("cyc dp_start", 64'(dp_start), 64'(xs));
      chk("cyc dp_en", 64'(dp_en), 64'(xe));
      chk("cyc dp_a", 64'(dp_a), 64'(xa));
      chk("cyc dp_b", 64'(dp_b), 64'(xb));
      chk("cyc dp_op", 64'(dp_op), 64'(xo));
      chk("cyc rsp_valid", 64'(rsp_valid), 64'(m_done));
      chk("cyc rsp_err", 64'(rsp_err), 64'(m_err));
      if (m_done) chk("cyc rsp_data", rsp_data, m_data);
    end
  end

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_busy && n < 200);
    if (!m_busy) chk({tag, " accept timeout"}, 64'(m_busy), 64'(1));
  endtask

  task automatic do_cmd(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [15:0] prog, input logic [3:0] len, input logic [63:0] res,
                        input int hold, input int exp_lat, input logic [63:0] exp_data,
                        input logic exp_err);
    int lat;
    @(negedge clk);
    dp_res = res; cmd_a = a; cmd_b = b; cmd_prog = prog; cmd_len = len; cmd_valid = 1'b1;
    wait_accept(tag);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) cmd_valid = 1'b0;
    end while (!rsp_valid && lat < 200);
    cmd_valid = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " rsp_data"}, rsp_data, exp_data);
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold rsp_valid"}, 64'(rsp_valid), 64'(1));
      chk({tag, " hold cmd_ready"}, 64'(cmd_ready), 64'(0));
      chk({tag, " hold rsp_data"}, rsp_data, exp_data);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " rsp_valid cleared"}, 64'(rsp_valid), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " dp_start"}, 64'(dp_start), 64'(0));
    chk({tag, " dp_en"}, 64'(dp_en), 64'(0));
    chk({tag, " dp_a"}, 64'(dp_a), 64'(0));
    chk({tag, " dp_b"}, 64'(dp_b), 64'(0));
    chk({tag, " dp_op"}, 64'(dp_op), 64'(0));
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(0));
    chk({tag, " rsp_data"}, rsp_data, 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset cmd_ready", 64'(cmd_ready), 64'(1));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_cmd("T1", 64'h0F0F, 64'h00FF, 16'h0000, 4'd0, 64'h0F2D, 0, 36, 64'h0F2D, 1'b0);
    do_cmd("T2", 64'h5, 64'h3, 16'h0003, 4'd1, 64'h5, 0, 38, 64'h5, 1'b0);
    do_cmd("T3", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 16'h5555, 4'd15,
           64'hDEAD_BEEF_0BAD_F00D, 0, 44, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    do_cmd("T4", 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 16'h0000, 4'd0,
           64'h8765_4321_0FED_CBA9, 10, 36, 64'h8765_4321_0FED_CBA9, 1'b0);
    // S0 -op3-> S1 -op0-> S3, then the five-step S3 route to OUTPUT.
    do_cmd("T7", 64'h1111, 64'h2222, 16'h0003, 4'd2, 64'hC0DE, 0, 41, 64'hC0DE, 1'b0);

    // T5: reset lands while nibble 7 is on the bus.
    @(negedge clk);
    dp_res = 64'hFFFF; cmd_a = 64'h1234; cmd_b = 64'h4321; cmd_prog = '0; cmd_len = '0;
    cmd_valid = 1'b1;
    wait_accept("T5");
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("T5 in load k=7 dp_a", 64'(dp_a), 64'(4'h0));
    chk("T5 in load dp_en", 64'(dp_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_zero("T5 after reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_cmd("T5 fresh", 64'h0F0F, 64'h00FF, 16'h0000, 4'd0, 64'h0F2D, 0, 36, 64'h0F2D, 1'b0);

`ifdef FSM_SEQ_WDOG_EN
    stuck = 1'b1;
    do_cmd("T6", 64'h77, 64'h88, 16'h0000, 4'd0, 64'hFFFF, 0, 64, 64'h0, 1'b1);
    stuck = 1'b0;
    do_cmd("T6 after", 64'h5, 64'h3, 16'h0003, 4'd1, 64'h9, 0, 38, 64'h9, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
